arb_client: RTL and testbench

Requester-side agent for the 3-way fixed-priority arbiter: one instance drives one arbiter request line `r[i]` and watches the matching grant `g[i]`. It queues burst jobs from a local master, raises the request, emits one beat strobe per granted cycle until the burst length is consumed, then releases and waits for the grant to clear before requesting again. Three instances sit beside the arbiter, one per requester slot.

---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_job_fifo.sv | 38 +++
 rtl/arb_client.sv | 153 +++++++++++++++
 tb/tb_arb_client.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and defaults for the fixed-priority arbiter and its requester agents.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        REL    = 2'd2
    } arb_client_state_t;

    localparam int ARB_NUM_REQ     = 3;
    localparam int ARB_LEN_W_DEF   = 5;
    localparam int ARB_TIMEOUT_DEF = 255;

endpackage

// File: rtl/arb_job_fifo.sv
// Job-length FIFO for arb_client: power-of-two depth, wrap-bit pointers, async active-low reset.
module arb_job_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, rd_q;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !full_o) wr_q <= wr_q + 1'b1;
            if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/arb_client.sv
// Requester agent for one arbiter slot: queues burst jobs, requests, strobes beats, releases.
// Optional grant-wait timeout is built when ARB_CLIENT_TIMEOUT_EN is defined.
module arb_client
    import arb_pkg::*;
#(
    parameter int LEN_W   = ARB_LEN_W_DEF,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = ARB_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    output logic             req,
    input  logic             gnt,
    output logic             beat,
    output logic             last,
    output logic             busy,
    output logic             timeout
);
    arb_client_state_t state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              req_q, busy_q;
    logic              fifo_full, fifo_empty, push, pop_c, load;
    logic [LEN_W-1:0]  head, head_len;
    logic              beat_c, last_c, expired;

    assign job_ready = !fifo_full;
    assign push      = job_valid && !fifo_full;
    assign head_len  = (head == '0) ? LEN_W'(1) : head;

    arb_job_fifo #(.DEPTH(QDEPTH), .W(LEN_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (job_len),
        .pop_i   (pop_c),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop_c   = 1'b0;
        load    = 1'b0;
        beat_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    load    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (expired) begin
                    state_d = REL;
                end else if (gnt) begin
                    beat_c = 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        last_c  = 1'b1;
                        state_d = REL;
                    end
                end
            end
            REL: begin
                // Hold off until the arbiter has dropped our grant so it passes through idle.
                if (!gnt) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        load    = 1'b1;
                        state_d = ACTIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) rem_d = head_len;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            req_q   <= (state_d == ACTIVE);
            // When staying in IDLE nothing was popped, so the queue is non-empty next cycle iff it is now or a push lands.
            busy_q  <= (state_d != IDLE) || !fifo_empty || push;
        end
    end

    assign req  = req_q;
    assign busy = busy_q;
    assign beat = beat_c;
    assign last = last_c;

`ifdef ARB_CLIENT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          started_q, started_d, timeout_q, timeout_d;

    assign expired = (state_q == ACTIVE) && !started_q && (wcnt_q == TW'(TIMEOUT));

    always_comb begin
        wcnt_d    = wcnt_q;
        started_d = started_q;
        timeout_d = 1'b0;
        if (load) begin
            wcnt_d    = '0;
            started_d = 1'b0;
        end else if (state_q == ACTIVE && !expired) begin
            if (gnt) begin
                started_d = 1'b1;
                wcnt_d    = '0;
            end else if (!started_q) begin
                wcnt_d    = wcnt_q + 1'b1;
                timeout_d = (wcnt_q == TW'(TIMEOUT - 1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q    <= '0;
            started_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            started_q <= started_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign expired = 1'b0;
    // Constant 0; TIMEOUT has no effect in this build.
    assign timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_arb_client.sv
// Self-checking bench for arb_client: directed scenarios plus randomized jobs/grants vs a job-level model.
module tb_arb_client;
    localparam int LW = 5;
    localparam int QD = 2;
    localparam int TO = 8;
`ifdef ARB_CLIENT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          job_valid = 1'b0;
    logic [LW-1:0] job_len = '0;
    logic          gnt = 1'b0;
    logic          job_ready, req, beat, last, busy, timeout;

    always #5 clk = ~clk;

    arb_client #(.LEN_W(LW), .QDEPTH(QD), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_len   (job_len),
        .req       (req),
        .gnt       (gnt),
        .beat      (beat),
        .last      (last),
        .busy      (busy),
        .timeout   (timeout)
    );

    // Job-level model: pending lengths, beats left on the owned job, and a wait-for-grant-clear flag.
    int q[$];
    int cur = 0;
    int waited = 0;
    bit started = 1'b0;
    bit wclr = 1'b0;

    int checks = 0;
    int errors = 0;
    int nbeats = 0, nlast = 0, nto = 0, idle_req = 0;
    int gmode = 0;
    int glow = 0;
    bit req_prev_obs = 1'b0;
    bit gnt_prev = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_idle();
        return (cur == 0) && !wclr && (q.size() == 0);
    endfunction

    // Entered and left #1 after a rising edge with inputs for this cycle already applied.
    task automatic cycle();
        bit e_req, e_exp, e_beat, e_last, e_busy, e_rdy, push_ok, g;
        int len;
        @(negedge clk);
        e_req  = (cur > 0);
        e_exp  = TO_EN && (cur > 0) && !started && (waited == TO);
        e_beat = (cur > 0) && gnt && !e_exp;
        e_last = e_beat && (cur == 1);
        e_busy = (cur > 0) || wclr || (q.size() > 0);
        e_rdy  = (q.size() < QD);
        chk("req", req, e_req);
        chk("beat", beat, e_beat);
        chk("last", last, e_last);
        chk("busy", busy, e_busy);
        chk("job_ready", job_ready, e_rdy);
        chk("timeout", timeout, e_exp);
        if (gmode == 0 && req === 1'b1 && !req_prev_obs)
            chk("rereq_gnt_clear", gnt_prev, 1'b0);
        if (e_beat) nbeats++;
        if (e_last) nlast++;
        if (e_exp) nto++;
        if (e_req && !e_beat) idle_req++;
        req_prev_obs = (req === 1'b1);
        g = gnt;
        gnt_prev = g;
        push_ok = job_valid && e_rdy;
        len = (job_len == '0) ? 1 : int'(job_len);
        @(posedge clk);
        if (cur > 0) begin
            if (e_exp) begin
                cur = 0;
                wclr = 1'b1;
            end else if (e_beat) begin
                cur--;
                started = 1'b1;
                if (cur == 0) wclr = 1'b1;
            end else if (!started) begin
                waited++;
            end
        end else if (wclr) begin
            if (!g) begin
                wclr = 1'b0;
                if (q.size() > 0) begin
                    cur = q.pop_front();
                    started = 1'b0;
                    waited = 0;
                end
            end
        end else if (q.size() > 0) begin
            cur = q.pop_front();
            started = 1'b0;
            waited = 0;
        end
        if (push_ok) q.push_back(len);
        #1;
        if (glow > 0) begin
            gnt = 1'b0;
            glow--;
        end else begin
            case (gmode)
                0: gnt = e_req;
                1: gnt = e_req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
                default: gnt = 1'b0;
            endcase
        end
    endtask

    task automatic push_job(input int len);
        job_valid = 1'b1;
        job_len = LW'(len);
        cycle();
        job_valid = 1'b0;
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while (!model_idle() && n < maxc) begin
            cycle();
            n++;
        end
        chki("drain_in_budget", int'(n < maxc), 1);
        cycle();
        cycle();
    endtask

    task automatic clr_counts();
        nbeats = 0; nlast = 0; nto = 0; idle_req = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_req_async", req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", job_ready, 1'b1);
        q.delete();
        cur = 0; waited = 0; started = 1'b0; wclr = 1'b0;
        job_valid = 1'b0;
        gnt = 1'b0;
        req_prev_obs = 1'b0;
        gnt_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bit done;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", req, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_timeout", timeout, 1'b0);
        chk("reset_ready", job_ready, 1'b1);
        chk("reset_beat", beat, 1'b0);
        rst = 1'b1;
        cycle();

        // Single job of 3 with grant following request by one cycle.
        gmode = 0;
        clr_counts();
        push_job(3);
        run_idle(40);
        chki("len3_beats", nbeats, 3);
        chki("len3_last", nlast, 1);
        chki("len3_wait", idle_req, 1);

        // Zero length counts as one beat.
        clr_counts();
        push_job(0);
        run_idle(40);
        chki("len0_beats", nbeats, 1);
        chki("len0_last", nlast, 1);

        // Back-to-back jobs fill a depth-2 queue without back-pressure.
        clr_counts();
        chk("b2b_ready1", job_ready, 1'b1);
        push_job(2);
        chk("b2b_ready2", job_ready, 1'b1);
        push_job(1);
        run_idle(40);
        chki("b2b_beats", nbeats, 3);
        chki("b2b_last", nlast, 2);

        // Grant withdrawn for two cycles mid-burst.
        clr_counts();
        done = 1'b0;
        push_job(4);
        for (int i = 0; i < 30 && !model_idle(); i++) begin
            cycle();
            if (nbeats == 2 && !done) begin
                gnt = 1'b0;
                glow = 1;
                done = 1'b1;
            end
        end
        run_idle(40);
        chki("gap_beats", nbeats, 4);
        chki("gap_req_no_beat", idle_req, 3);

        // Reset during beat 2 of 4 with a second job queued.
        clr_counts();
        done = 1'b0;
        push_job(4);
        push_job(3);
        for (int i = 0; i < 20 && !done; i++) begin
            if (nbeats == 1) begin
                do_reset();
                done = 1'b1;
            end else begin
                cycle();
            end
        end
        chk("midrst_seen", done, 1'b1);
        cycle();
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", job_ready, 1'b1);
        chk("midrst_req", req, 1'b0);

`ifdef ARB_CLIENT_TIMEOUT_EN
        // Grant never arrives: first job is dropped, queued job is then served.
        clr_counts();
        gmode = 2;
        push_job(2);
        push_job(1);
        for (int i = 0; i < 40 && nto == 0; i++) cycle();
        gmode = 0;
        run_idle(60);
        chki("to_pulses", nto, 1);
        chki("to_beats", nbeats, 1);
`endif

        // Randomized jobs and grants.
        gmode = 1;
        for (int i = 0; i < 400; i++) begin
            job_valid = ($urandom_range(0, 9) < 3);
            job_len = LW'($urandom_range(0, 6));
            cycle();
        end
        job_valid = 1'b0;
        gmode = 0;
        run_idle(200);
        chk("final_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
